// File: rtl/uartrx_param_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM state encodings
// and default bit periods for a 100 MHz system clock.
package uartrx_param_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam int CLKS_9600_100M   = 10416;
  localparam int CLKS_115200_100M = 868;

endpackage

// File: rtl/uartrx_param_sync_2ff.sv
// Two-flop synchroniser for asynchronous single-bit inputs; RST_VAL selects
// the value both flops take during reset (1 for an idle-high serial line).
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uartrx_param.sv
// Parametrised UART receiver (LSB first, 1 stop bit) with start-glitch rejection
// and framing check. Define UARTRX_PARITY_EN to add a parity bit and parity_err.
module uartrx_param
  import uartrx_param_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_9600_100M,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy,
  output logic [2:0]           out_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       BIT_LAST = 4'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uartrx_param: parameter out of legal range");
  end

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] dout_q;
  logic                 dout_valid_q;
  logic                 frame_err_q;
  logic                 rx_prev_q;
  logic                 rx_s;
  logic                 fall;

  sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (rx),
    .q    (rx_s)
  );

  // A held-low line never produces an edge, so it cannot start a frame.
  assign fall = rx_prev_q & ~rx_s;

`ifdef UARTRX_PARITY_EN
  localparam logic PAR_INV = (PARITY_ODD != 0);
  logic par_bad_q;
  logic parity_err_q;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_prev_q    <= 1'b1;
`ifdef UARTRX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_prev_q    <= rx_s;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UARTRX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (!en) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        bit_q   <= '0;
        shift_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (fall) begin
              state_q <= ST_START;
              cnt_q   <= '0;
            end
          end
          ST_START: begin
            if (cnt_q == CNT_MID) begin
              cnt_q <= '0;
              bit_q <= '0;
              if (rx_s) state_q <= ST_IDLE;
              else      state_q <= ST_DATA;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          // Counter restarted at the start-bit centre, so each wrap lands mid-bit.
          ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
              if (bit_q == BIT_LAST) begin
`ifdef UARTRX_PARITY_EN
                state_q <= ST_PARITY;
`else
                state_q <= ST_STOP;
`endif
              end else begin
                bit_q <= bit_q + 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
`ifdef UARTRX_PARITY_EN
          ST_PARITY: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q     <= '0;
              par_bad_q <= rx_s ^ (^shift_q) ^ PAR_INV;
              state_q   <= ST_STOP;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
`endif
          // Leave at mid-stop so a back-to-back start edge is not missed.
          ST_STOP: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              state_q <= ST_IDLE;
              if (rx_s) begin
                dout_q       <= shift_q;
                dout_valid_q <= 1'b1;
`ifdef UARTRX_PARITY_EN
                parity_err_q <= par_bad_q;
`endif
              end else begin
                frame_err_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != ST_IDLE);
  assign out_state  = state_q;
`ifdef UARTRX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uartrx_param.sv
// Scoreboard bench for uartrx_param: DUT A at 16 clks/bit, DUT B at 868 clks/bit
// for the back-to-back case. Parity frames are exercised when UARTRX_PARITY_EN is set.
module tb_uartrx_param;
  import uartrx_param_pkg::*;

  localparam int CPB_A = 16;
  localparam int CPB_B = CLKS_115200_100M;
`ifdef UARTRX_PARITY_EN
  localparam bit USE_PAR = 1'b1;
`else
  localparam bit USE_PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic en_a = 1'b1, rx_a = 1'b1, en_b = 1'b1, rx_b = 1'b1;
  logic [7:0] dout_a, dout_b;
  logic dv_a, fe_a, pe_a, busy_a, dv_b, fe_b, pe_b, busy_b;
  logic [2:0] st_a, st_b;

  always #5 clk = ~clk;

  uartrx_param #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(8), .PARITY_ODD(0)) u_dut_a (
    .clk(clk), .nrst(nrst), .en(en_a), .rx(rx_a), .dout(dout_a), .dout_valid(dv_a),
    .frame_err(fe_a), .parity_err(pe_a), .busy(busy_a), .out_state(st_a));

  uartrx_param #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(8), .PARITY_ODD(0)) u_dut_b (
    .clk(clk), .nrst(nrst), .en(en_b), .rx(rx_b), .dout(dout_b), .dout_valid(dv_b),
    .frame_err(fe_b), .parity_err(pe_b), .busy(busy_b), .out_state(st_b));

  typedef struct {
    logic       fe;
    logic [7:0] d;
    logic       pe;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_bit(input int sel, input logic b);
    if (sel == 0) begin
      rx_a = b;
      repeat (CPB_A) @(negedge clk);
    end else begin
      rx_b = b;
      repeat (CPB_B) @(negedge clk);
    end
  endtask

  task automatic idle_bits(input int sel, input int n);
    for (int i = 0; i < n; i++) drive_bit(sel, 1'b1);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input logic par, input logic stop);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (USE_PAR) drive_bit(sel, par);
    drive_bit(sel, stop);
  endtask

  task automatic push(input int sel, input logic fe, input logic [7:0] d, input logic pe);
    exp_t e;
    e.fe = fe; e.d = d; e.pe = pe;
    if (sel == 0) qa.push_back(e);
    else          qb.push_back(e);
  endtask

  // Monitors: every strobe must match the head of its queue; a strobe with
  // nothing queued (including a second cycle of a pulse) is an error.
  always @(negedge clk) begin
    if (nrst && (dv_a || fe_a || pe_a)) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_strobe: dv=%0b fe=%0b pe=%0b dout=0x%0h expected none", dv_a, fe_a, pe_a, dout_a);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_strobe_kind", {dv_a, fe_a}, e.fe ? 2'b01 : 2'b10);
        chk("a_dout", dout_a, e.d);
        chk("a_parity_err", pe_a, e.pe);
      end
    end
  end

  always @(negedge clk) begin
    if (nrst && (dv_b || fe_b || pe_b)) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_strobe: dv=%0b fe=%0b pe=%0b dout=0x%0h expected none", dv_b, fe_b, pe_b, dout_b);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_strobe_kind", {dv_b, fe_b}, e.fe ? 2'b01 : 2'b10);
        chk("b_dout", dout_b, e.d);
        chk("b_parity_err", pe_b, e.pe);
      end
    end
  end

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_dout", dout_a, 0);
    chk("rst_dout_valid", dv_a, 0);
    chk("rst_frame_err", fe_a, 0);
    chk("rst_parity_err", pe_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_state", st_a, 0);
    chk("rst_dout_b", dout_b, 0);
    nrst = 1'b1;
    idle_bits(0, 2);

    // Frame 0x45, good stop
    push(0, 1'b0, 8'h45, 1'b0);
    send_frame(0, 8'h45, 1'b1, 1'b1);
    idle_bits(0, 2);

    // Start glitch of 3 clocks
    rx_a = 1'b0;
    repeat (3) @(negedge clk);
    rx_a = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_in_start", st_a, 1);
    repeat (11) @(negedge clk);
    chk("glitch_back_idle", st_a, 0);
    idle_bits(0, 1);

    // Framing error keeps old dout, then a good frame
    push(0, 1'b1, 8'h45, 1'b0);
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    idle_bits(0, 2);
    push(0, 1'b0, 8'hA5, 1'b0);
    send_frame(0, 8'hA5, 1'b0, 1'b1);
    idle_bits(0, 2);

    // Enable dropped in data bit 3
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    rx_a = 1'b1;
    repeat (CPB_A / 2) @(negedge clk);
    chk("busy_before_en_drop", busy_a, 1);
    en_a = 1'b0;
    @(negedge clk);
    chk("busy_after_en_drop", busy_a, 0);
    chk("dout_held_en_drop", dout_a, 8'hA5);
    idle_bits(0, 8);
    en_a = 1'b1;
    idle_bits(0, 2);
    push(0, 1'b0, 8'h81, 1'b0);
    send_frame(0, 8'h81, 1'b0, 1'b1);
    idle_bits(0, 2);

`ifdef UARTRX_PARITY_EN
    // Even parity: 0x45 has three ones, so the correct parity bit is 1
    push(0, 1'b0, 8'h45, 1'b0);
    send_frame(0, 8'h45, 1'b1, 1'b1);
    idle_bits(0, 2);
    push(0, 1'b0, 8'h45, 1'b1);
    send_frame(0, 8'h45, 1'b0, 1'b1);
    idle_bits(0, 2);
`endif

    // Back-to-back frames with no idle gap on the slower DUT
    idle_bits(1, 1);
    push(1, 1'b0, 8'h00, 1'b0);
    push(1, 1'b0, 8'hFF, 1'b0);
    send_frame(1, 8'h00, 1'b0, 1'b1);
    send_frame(1, 8'hFF, 1'b0, 1'b1);
    idle_bits(1, 2);

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
